// File: rtl/mux2_rr_arbiter.sv
// Round-robin owner of a shared 2:1 mux select, with a bounded hold time per grant
// and a registered copy of the selected data.
module mux2_rr_arbiter #(
    parameter int WIDTH    = 1,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             s,
    output logic [WIDTH-1:0] out,
    output logic             out_valid
);

    generate
        if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
            $error("mux2_rr_arbiter: MAX_HOLD must be in 1..255");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t           r_state, w_state_next;
    logic             r_ptr, w_ptr_next;
    logic [7:0]       r_hold_cnt, w_hold_next;
    logic             w_at_limit;
    logic [WIDTH-1:0] r_out;
    logic             r_out_valid;

    assign w_at_limit = (r_hold_cnt == HOLD_LAST);

    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        w_hold_next  = r_hold_cnt;
        unique case (r_state)
            IDLE: begin
                if (req0 && req1)  w_state_next = r_ptr ? G1 : G0;
                else if (req0)     w_state_next = G0;
                else if (req1)     w_state_next = G1;
            end
            G0: begin
                // A dropped request takes precedence over the hold limit; both lead to G1 anyway.
                if (!req0)                    w_state_next = req1 ? G1 : IDLE;
                else if (req1 && w_at_limit)  w_state_next = G1;
            end
            G1: begin
                if (!req1)                    w_state_next = req0 ? G0 : IDLE;
                else if (req0 && w_at_limit)  w_state_next = G0;
            end
            default: w_state_next = IDLE;
        endcase

        if (r_state != IDLE && w_state_next != r_state) begin
            w_ptr_next = (r_state == G0);
        end

        if (r_state == IDLE || w_state_next != r_state) begin
            w_hold_next = 8'd0;
        end else if (!w_at_limit) begin
            w_hold_next = r_hold_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_ptr      <= 1'b0;
            r_hold_cnt <= 8'd0;
        end else begin
            r_state    <= w_state_next;
            r_ptr      <= w_ptr_next;
            r_hold_cnt <= w_hold_next;
        end
    end

    // Data is captured from the cycle the owner was actually requesting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= (gnt0 && req0) || (gnt1 && req1);
            if (gnt0 && req0)      r_out <= i0;
            else if (gnt1 && req1) r_out <= i1;
        end
    end

    assign gnt0      = (r_state == G0);
    assign gnt1      = (r_state == G1);
    assign s         = (r_state == G1);
    assign out       = r_out;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Randomized scoreboard bench: two arbiters (hold limits 4 and 1) share stimulus and are
// checked against an owner/cycles-held reference model.
module tb_mux2_rr_arbiter;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0 = 1'b0, req1 = 1'b0;
    logic [W-1:0] i0 = '0, i1 = '0;
    logic         g0a, g1a, sa, ova, g0b, g1b, sb, ovb;
    logic [W-1:0] outa, outb;

    always #5 clk = ~clk;

    mux2_rr_arbiter #(.WIDTH(W), .MAX_HOLD(4)) dut_a (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1), .i0(i0), .i1(i1),
        .gnt0(g0a), .gnt1(g1a), .s(sa), .out(outa), .out_valid(ova)
    );

    mux2_rr_arbiter #(.WIDTH(W), .MAX_HOLD(1)) dut_b (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1), .i0(i0), .i1(i1),
        .gnt0(g0b), .gnt1(g1b), .s(sb), .out(outb), .out_valid(ovb)
    );

    typedef struct packed {
        logic         g0;
        logic         g1;
        logic         s;
        logic [W-1:0] out;
        logic         ov;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    // Reference: who owns the mux (-1 none), how many cycles it has owned it, whose turn on a tie.
    int           owner[2];
    int           held[2];
    int           pref[2];
    logic [W-1:0] mout[2];
    logic         mov[2];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    function automatic int mh(int d);
        return (d == 0) ? 4 : 1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            owner[d] = -1;
            held[d]  = 0;
            pref[d]  = 0;
            mout[d]  = '0;
            mov[d]   = 1'b0;
        end
    endtask

    task automatic model_step(input int d, input logic r0, input logic r1,
                              input logic [W-1:0] d0, input logic [W-1:0] d1);
        logic [1:0] rq;
        int         nxt;
        exp_t       e;
        rq = {r1, r0};
        if (owner[d] >= 0 && rq[owner[d]]) begin
            mov[d]  = 1'b1;
            mout[d] = (owner[d] == 0) ? d0 : d1;
        end else begin
            mov[d] = 1'b0;
        end
        if (owner[d] < 0)
            nxt = (r0 && r1) ? pref[d] : (r0 ? 0 : (r1 ? 1 : -1));
        else if (!rq[owner[d]])
            nxt = rq[1 - owner[d]] ? 1 - owner[d] : -1;
        else if (rq[1 - owner[d]] && held[d] >= mh(d))
            nxt = 1 - owner[d];
        else
            nxt = owner[d];
        if (nxt == owner[d]) begin
            if (nxt >= 0) held[d]++;
        end else begin
            if (owner[d] >= 0) pref[d] = 1 - owner[d];
            held[d] = (nxt >= 0) ? 1 : 0;
        end
        owner[d] = nxt;
        e.g0  = (nxt == 0);
        e.g1  = (nxt == 1);
        e.s   = (nxt == 1);
        e.out = mout[d];
        e.ov  = mov[d];
        if (d == 0) qa.push_back(e);
        else        qb.push_back(e);
    endtask

    task automatic apply(input logic r0, input logic r1);
        req0 = r0;
        req1 = r1;
        i0   = W'($urandom);
        i1   = W'($urandom);
        model_step(0, r0, r1, i0, i1);
        model_step(1, r0, r1, i0, i1);
    endtask

    task automatic drive(input logic r0, input logic r1);
        @(negedge clk);
        apply(r0, r1);
    endtask

    task automatic cmp(input string nm, input exp_t want, input exp_t got);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got g0=%b g1=%b s=%b out=%h ov=%b want g0=%b g1=%b s=%b out=%h ov=%b",
                     nm, cyc, got.g0, got.g1, got.s, got.out, got.ov,
                     want.g0, want.g1, want.s, want.out, want.ov);
        end else begin
            $display("txn %s cyc=%0d g0=%b g1=%b s=%b out=%h ov=%b",
                     nm, cyc, got.g0, got.g1, got.s, got.out, got.ov);
        end
    endtask

    // Monitor: one popped expectation per DUT per clock, sampled just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (qa.size() > 0) begin
                e = qa.pop_front();
                cmp("hold4", e, {g0a, g1a, sa, outa, ova});
            end
            if (qb.size() > 0) begin
                e = qb.pop_front();
                cmp("hold1", e, {g0b, g1b, sb, outb, ovb});
            end
        end
    end

    initial begin
        logic r0, r1;
        model_reset();
        #7;
        cmp("reset_hold4", '0, {g0a, g1a, sa, outa, ova});
        cmp("reset_hold1", '0, {g0b, g1b, sb, outb, ovb});
        @(negedge clk);
        rst = 1'b0;
        apply(1'b0, 1'b0);

        // Park both arbiters in G1, then reset asynchronously in the middle of a cycle.
        repeat (4) drive(1'b0, 1'b1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        cmp("async_rst_hold4", '0, {g0a, g1a, sa, outa, ova});
        cmp("async_rst_hold1", '0, {g0b, g1b, sb, outb, ovb});
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        apply(1'b1, 1'b1);

        repeat (20) drive(1'b1, 1'b1);
        repeat (10) drive(1'b1, 1'b0);
        repeat (3)  drive(1'b0, 1'b0);
        repeat (2)  drive(1'b1, 1'b1);
        repeat (3)  drive(1'b0, 1'b1);
        repeat (4)  drive(1'b1, 1'b1);

        r0 = 1'b1;
        r1 = 1'b1;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(4, 0) == 0) r0 = ~r0;
            if ($urandom_range(4, 0) == 0) r1 = ~r1;
            drive(r0, r1);
        end

        repeat (3) drive(1'b0, 1'b0);
        @(posedge clk);
        #3;
        n_cmp++;
        if (qa.size() != 0 || qb.size() != 0) begin
            n_bad++;
            $display("FAIL drain got %0d/%0d pending want 0/0", qa.size(), qb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
